spect_dma_writer: RTL and testbench

SPECT_DMA_WRITER -- requirements
Module: spect_dma_writer

---
 rtl/spect_dma_writer.sv | 189 ++++++++++++++++++
 tb/tb_spect_dma_writer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spect_dma_writer.sv
`timescale 1ns/1ps
// spect_dma_writer
// Packs a 16-bit spectrum sample stream into 32-bit words and writes them to a
// destination window through an AHB-Lite master port, one SINGLE write at a time.
//
// Ports
//   hclk, hresetn          clock, asynchronous active-low reset
//   ce                     clock enable; low freezes all state and drops tready_s
//   start                  one-cycle pulse arming a capture (ignored unless idle)
//   base_addr, len_words   destination window, sampled on start (len 0 = 2^LEN_W)
//   tdata_s/tlast_s/
//   tvalid_s/tready_s      sample stream, low half first
//   h*_m                   AHB-Lite master (IDLE/NONSEQ, word, SINGLE, write only)
//   busy                   capture in progress
//   done_irq, err_irq      one-cycle completion / bus-error pulses
//   overrun                sticky: frame longer than the window, cleared on start
module spect_dma_writer #(
   parameter int unsigned LEN_W = 11
) (
   input  logic             hclk,
   input  logic             hresetn,
   input  logic             ce,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [LEN_W-1:0] len_words,
   input  logic [15:0]      tdata_s,
   input  logic             tlast_s,
   input  logic             tvalid_s,
   output logic             tready_s,
   output logic [31:0]      haddr_m,
   output logic [1:0]       htrans_m,
   output logic [2:0]       hsize_m,
   output logic [2:0]       hburst_m,
   output logic             hwrite_m,
   output logic [31:0]      hwdata_m,
   input  logic             hready_m,
   input  logic             hresp_m,
   output logic             busy,
   output logic             done_irq,
   output logic             err_irq,
   output logic             overrun
);

   typedef enum logic [2:0] {
      StIdle,
      StFill,
      StAddr,
      StData,
      StDrain,
      StDone,
      StErr
   } state_e;

   state_e         state_q, state_d;
   logic [31:0]    base_q, base_d;
   // One extra bit so a zero length can be held as 2^LEN_W.
   logic [LEN_W:0] len_q, len_d;
   logic [LEN_W:0] count_q, count_d;
   logic [LEN_W:0] count_inc;
   logic [31:0]    wdata_q, wdata_d;
   logic           hi_q, hi_d;       // next accepted sample goes to the upper half
   logic           last_q, last_d;   // tlast of the frame already accepted
   logic           abort_q, abort_d; // frame aborted by a bus error
   logic           ovr_q, ovr_d;
   logic           accept;

   assign count_inc = count_q + {{LEN_W{1'b0}}, 1'b1};
   assign tready_s  = ce && ((state_q == StFill) || (state_q == StDrain));
   assign accept    = tvalid_s && tready_s;

   assign haddr_m  = base_q + (32'(count_q) << 2);
   assign htrans_m = (state_q == StAddr) ? 2'b10 : 2'b00;
   assign hsize_m  = 3'b010;
   assign hburst_m = 3'b000;
   assign hwrite_m = 1'b1;
   assign hwdata_m = wdata_q;
   assign busy     = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);
   assign done_irq = (state_q == StDone);
   assign err_irq  = (state_q == StErr);
   assign overrun  = ovr_q;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      count_d = count_q;
      wdata_d = wdata_q;
      hi_d    = hi_q;
      last_d  = last_q;
      abort_d = abort_q;
      ovr_d   = ovr_q;
      if (ce) begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_d = StFill;
                  base_d  = {base_addr[31:2], 2'b00};
                  len_d   = (len_words == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_words};
                  count_d = '0;
                  hi_d    = 1'b0;
                  last_d  = 1'b0;
                  abort_d = 1'b0;
                  ovr_d   = 1'b0;
               end
            end
            StFill: begin
               if (accept) begin
                  if (!hi_q) begin
                     // Upper half is zeroed so a short final word carries no stale data.
                     wdata_d = {16'h0000, tdata_s};
                     if (tlast_s) begin
                        last_d  = 1'b1;
                        state_d = StAddr;
                     end else begin
                        hi_d = 1'b1;
                     end
                  end else begin
                     wdata_d[31:16] = tdata_s;
                     hi_d           = 1'b0;
                     last_d         = tlast_s;
                     state_d        = StAddr;
                  end
               end
            end
            StAddr: begin
               if (hready_m) begin
                  state_d = StData;
               end
            end
            StData: begin
               // htrans_m is already IDLE here, so the first error cycle is enough to bail.
               if (hresp_m) begin
                  abort_d = 1'b1;
                  state_d = StErr;
               end else if (hready_m) begin
                  count_d = count_inc;
                  if (last_q) begin
                     state_d = StDone;
                  end else if (count_inc == len_q) begin
                     ovr_d   = 1'b1;
                     state_d = StDrain;
                  end else begin
                     state_d = StFill;
                  end
               end
            end
            StDrain: begin
               if (accept && tlast_s) begin
                  state_d = abort_q ? StIdle : StDone;
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            StErr: begin
               state_d = last_q ? StIdle : StDrain;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q <= StIdle;
         base_q  <= '0;
         len_q   <= '0;
         count_q <= '0;
         wdata_q <= '0;
         hi_q    <= 1'b0;
         last_q  <= 1'b0;
         abort_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         count_q <= count_d;
         wdata_q <= wdata_d;
         hi_q    <= hi_d;
         last_q  <= last_d;
         abort_q <= abort_d;
         ovr_q   <= ovr_d;
      end
   end

endmodule

// File: tb/tb_spect_dma_writer.sv
`timescale 1ns/1ps
// Scoreboard bench for spect_dma_writer: frames are turned into expected AHB writes by a
// word-level model, a bus-slave monitor compares completed writes as they happen.
module tb_spect_dma_writer;

   localparam int unsigned LW = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic          hclk = 1'b0;
   logic          hresetn = 1'b1;
   logic          ce = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   base_addr = '0;
   logic [LW-1:0] len_words = '0;
   logic [15:0]   tdata_s = '0;
   logic          tlast_s = 1'b0;
   logic          tvalid_s = 1'b0;
   logic          tready_s;
   logic [31:0]   haddr_m;
   logic [1:0]    htrans_m;
   logic [2:0]    hsize_m;
   logic [2:0]    hburst_m;
   logic          hwrite_m;
   logic [31:0]   hwdata_m;
   logic          hready_m = 1'b1;
   logic          hresp_m = 1'b0;
   logic          busy;
   logic          done_irq;
   logic          err_irq;
   logic          overrun;

   spect_dma_writer #(.LEN_W(LW)) dut (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .ce        (ce),
      .start     (start),
      .base_addr (base_addr),
      .len_words (len_words),
      .tdata_s   (tdata_s),
      .tlast_s   (tlast_s),
      .tvalid_s  (tvalid_s),
      .tready_s  (tready_s),
      .haddr_m   (haddr_m),
      .htrans_m  (htrans_m),
      .hsize_m   (hsize_m),
      .hburst_m  (hburst_m),
      .hwrite_m  (hwrite_m),
      .hwdata_m  (hwdata_m),
      .hready_m  (hready_m),
      .hresp_m   (hresp_m),
      .busy      (busy),
      .done_irq  (done_irq),
      .err_irq   (err_irq),
      .overrun   (overrun)
   );

   always #5 hclk = ~hclk;

   int          checks = 0;
   int          errors = 0;
   wr_t         exp_q[$];
   logic [16:0] src_q[$];   // {tlast, data}
   logic [15:0] stim[$];
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          wr_cnt = 0;
   int          naddr_cnt = 0;
   int          err_at = -1;
   int          wr_idx = 0;
   int          wait_mode = 0; // 0: no waits, 1: random waits, 2: three waits per phase
   bit          src_rand = 1'b0;
   bit          dphase = 1'b0;
   bit          err2 = 1'b0;
   bit          a_first = 1'b1;
   bit          d_first = 1'b1;
   int          phase_cyc = 0;
   logic [31:0] a_hold, d_hold, cur_addr;
   wr_t         sb_e;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
      end
   endfunction

   // Stream source: presents queued samples, pops on handshake.
   initial begin
      forever begin
         @(negedge hclk);
         if (!hresetn || src_q.size() == 0) begin
            tvalid_s = 1'b0;
         end else begin
            tvalid_s = src_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            tdata_s  = src_q[0][15:0];
            tlast_s  = src_q[0][16];
            if (tvalid_s && tready_s) void'(src_q.pop_front());
         end
      end
   end

   // AHB slave and write monitor.
   initial begin
      forever begin
         @(negedge hclk);
         if (!hresetn) begin
            dphase = 1'b0; err2 = 1'b0; a_first = 1'b1; phase_cyc = 0;
            hready_m = 1'b1; hresp_m = 1'b0;
         end else begin
            hresp_m = 1'b0;
            case (wait_mode)
               0:       hready_m = 1'b1;
               1:       hready_m = ($urandom_range(0, 2) != 0);
               default: hready_m = (phase_cyc >= 3);
            endcase
            if (err2) begin
               hready_m = 1'b1; hresp_m = 1'b1;
               if (ce) err2 = 1'b0;
            end else if (dphase) begin
               chk("htrans_idle_in_data", 32'(htrans_m), 32'h0);
               if (d_first) begin
                  d_hold = hwdata_m; d_first = 1'b0;
               end else begin
                  chk("hwdata_stable", hwdata_m, d_hold);
               end
               if (wr_idx == err_at) begin
                  hready_m = 1'b0; hresp_m = 1'b1;
                  if (ce) begin
                     dphase = 1'b0; err2 = 1'b1; wr_idx++; phase_cyc = 0;
                  end
               end else if (hready_m && ce) begin
                  if (exp_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL unexpected_write: got 0x%08h@0x%08h, none expected",
                              hwdata_m, cur_addr);
                  end else begin
                     sb_e = exp_q.pop_front();
                     chk("write_addr", cur_addr, sb_e.addr);
                     chk("write_data", hwdata_m, sb_e.data);
                  end
                  wr_cnt++; wr_idx++; dphase = 1'b0; phase_cyc = 0;
               end else if (ce) begin
                  phase_cyc++;
               end
            end else if (htrans_m == 2'b10) begin
               if (a_first) begin
                  a_hold = haddr_m; a_first = 1'b0;
                  chk("ahb_ctrl", 32'({hwrite_m, hburst_m, hsize_m}), 32'h42);
               end else begin
                  chk("haddr_stable", haddr_m, a_hold);
               end
               if (hready_m && ce) begin
                  dphase = 1'b1; d_first = 1'b1; a_first = 1'b1;
                  cur_addr = haddr_m; naddr_cnt++; phase_cyc = 0;
               end else if (ce) begin
                  phase_cyc++;
               end
            end else begin
               if (!a_first) begin
                  chk("htrans_held", 32'(htrans_m), 32'h2);
                  a_first = 1'b1;
               end
               phase_cyc = 0;
            end
         end
      end
   end

   // Interrupt counter and clock-enable check.
   initial begin
      forever begin
         @(negedge hclk);
         if (hresetn) begin
            if (done_irq && ce) done_cnt++;
            if (err_irq && ce) err_cnt++;
            if (!ce) chk("tready_ce_low", 32'(tready_s), 32'h0);
         end
      end
   end

   task automatic run_frame(input logic [31:0] base, input int len, input int err_i,
                            input int wm, input bit rand_ce, input bit rand_src);
      int          n, len_eff, nw, nwr, exp_ok, cyc;
      bit          exp_ovr;
      wr_t         w;
      logic [31:0] b4;
      n       = stim.size();
      len_eff = (len == 0) ? (1 << LW) : len;
      nw      = (n + 1) / 2;
      nwr     = (nw < len_eff) ? nw : len_eff;
      exp_ovr = (err_i < 0) && (nw > len_eff);
      exp_ok  = (err_i < 0) ? nwr : err_i;
      b4      = {base[31:2], 2'b00};
      exp_q.delete();
      for (int i = 0; i < exp_ok; i++) begin
         w.addr        = b4 + 32'(4 * i);
         w.data[15:0]  = stim[2 * i];
         w.data[31:16] = (2 * i + 1 < n) ? stim[2 * i + 1] : 16'h0000;
         exp_q.push_back(w);
      end
      err_at = err_i; wr_idx = 0; wr_cnt = 0; naddr_cnt = 0;
      done_cnt = 0; err_cnt = 0; wait_mode = wm; src_rand = rand_src;
      @(posedge hclk); #1;
      ce = 1'b1; base_addr = base; len_words = LW'(len); start = 1'b1;
      for (int i = 0; i < n; i++) src_q.push_back({(i == n - 1), stim[i]});
      @(posedge hclk); #1;
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'h1);
      chk("overrun_cleared", 32'(overrun), 32'h0);
      cyc = 0;
      while (!(busy == 1'b0 && src_q.size() == 0) && cyc < 2000) begin
         @(posedge hclk); #1;
         ce = rand_ce ? ($urandom_range(0, 4) != 0) : 1'b1;
         cyc++;
      end
      if (cyc >= 2000) begin
         checks++; errors++;
         $display("FAIL frame_timeout: busy=%0d samples_left=%0d want idle", busy, src_q.size());
      end
      ce = 1'b1;
      repeat (4) @(posedge hclk);
      #1;
      chk("writes_done", 32'(wr_cnt), 32'(exp_ok));
      chk("addr_phases", 32'(naddr_cnt), 32'(exp_ok + ((err_i >= 0) ? 1 : 0)));
      chk("done_irq_count", 32'(done_cnt), (err_i < 0) ? 32'h1 : 32'h0);
      chk("err_irq_count", 32'(err_cnt), (err_i >= 0) ? 32'h1 : 32'h0);
      chk("overrun", 32'(overrun), 32'(exp_ovr));
      chk("busy_end", 32'(busy), 32'h0);
      chk("samples_consumed", 32'(src_q.size()), 32'h0);
      src_q.delete(); exp_q.delete(); err_at = -1;
   endtask

   initial begin
      int          n, len, e, nwr, len_eff, cyc;
      logic [31:0] b;
      #1 hresetn = 1'b0;
      #10;
      chk("rst_tready", 32'(tready_s), 32'h0);
      chk("rst_htrans", 32'(htrans_m), 32'h0);
      chk("rst_haddr", haddr_m, 32'h0);
      chk("rst_hwdata", hwdata_m, 32'h0);
      chk("rst_flags", 32'({busy, done_irq, err_irq, overrun}), 32'h0);
      @(posedge hclk); #3 hresetn = 1'b1;
      repeat (2) @(posedge hclk);

      // Even frame, zero wait states.
      stim.delete();
      for (int i = 1; i <= 6; i++) stim.push_back(16'(i));
      run_frame(32'h2000_0000, 4, -1, 0, 1'b0, 1'b0);

      // Odd frame: last word upper half zeroed.
      stim.delete();
      stim.push_back(16'h1111); stim.push_back(16'h2222); stim.push_back(16'h3333);
      run_frame(32'h1000_0040, 8, -1, 0, 1'b0, 1'b0);

      // Window of 2 words, 6 samples: overrun and drain.
      stim.delete();
      for (int i = 1; i <= 6; i++) stim.push_back(16'(16'hA000 + i));
      run_frame(32'h3000_0000, 2, -1, 0, 1'b0, 1'b0);

      // Three wait states in both phases.
      stim.delete();
      for (int i = 0; i < 4; i++) stim.push_back(16'($urandom));
      run_frame(32'h0000_1000, 4, -1, 2, 1'b0, 1'b0);

      // Bus error on the second write.
      stim.delete();
      for (int i = 0; i < 8; i++) stim.push_back(16'($urandom));
      run_frame(32'h5000_0000, 8, 1, 0, 1'b0, 1'b0);

      // Unaligned base wraps past 2^32.
      stim.delete();
      for (int i = 0; i < 8; i++) stim.push_back(16'($urandom));
      run_frame(32'hFFFF_FFF7, 5, -1, 1, 1'b0, 1'b1);

      // Zero length means 2^LW words: exact fit, then one sample over.
      stim.delete();
      for (int i = 0; i < 32; i++) stim.push_back(16'($urandom));
      run_frame(32'h0800_0000, 0, -1, 0, 1'b0, 1'b0);
      stim.push_back(16'h5A5A);
      run_frame(32'h0800_0100, 0, -1, 0, 1'b1, 1'b1);

      // Reset during a data phase.
      wait_mode = 0; src_rand = 1'b0; done_cnt = 0; err_cnt = 0;
      @(posedge hclk); #1;
      base_addr = 32'h6000_0000; len_words = LW'(8); start = 1'b1;
      for (int i = 0; i < 10; i++) src_q.push_back({(i == 9), 16'(i)});
      @(posedge hclk); #1;
      start = 1'b0;
      cyc = 0;
      while (!dphase && cyc < 200) begin
         @(posedge hclk); #2;
         cyc++;
      end
      chk("reached_data_phase", 32'(dphase), 32'h1);
      #1 hresetn = 1'b0;
      #1;
      chk("arst_tready", 32'(tready_s), 32'h0);
      chk("arst_htrans", 32'(htrans_m), 32'h0);
      chk("arst_haddr", haddr_m, 32'h0);
      chk("arst_hwdata", hwdata_m, 32'h0);
      chk("arst_flags", 32'({busy, done_irq, err_irq, overrun}), 32'h0);
      src_q.delete(); exp_q.delete();
      repeat (2) @(posedge hclk);
      #3 hresetn = 1'b1;
      done_cnt = 0; err_cnt = 0;
      repeat (10) @(posedge hclk);
      #1;
      chk("no_irq_after_reset", 32'(done_cnt + err_cnt), 32'h0);
      chk("idle_after_reset", 32'({busy, htrans_m}), 32'h0);
      stim.delete();
      for (int i = 0; i < 5; i++) stim.push_back(16'($urandom));
      run_frame(32'h7000_0200, 6, -1, 0, 1'b0, 1'b0);

      // Randomized frames.
      for (int f = 0; f < 14; f++) begin
         n       = $urandom_range(1, 40);
         len     = $urandom_range(0, 15);
         b       = $urandom;
         len_eff = (len == 0) ? (1 << LW) : len;
         nwr     = ((n + 1) / 2 < len_eff) ? (n + 1) / 2 : len_eff;
         e       = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nwr - 1) : -1;
         stim.delete();
         for (int i = 0; i < n; i++) stim.push_back(16'($urandom));
         run_frame(b, len, e, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog");
   end

endmodule
